// File: rtl/encoder_pkg.sv
// Shared types and quadrature code helpers for the encoder emulator and monitor.
package encoder_pkg;

  typedef enum logic [1:0] {
    s_idle,
    s_run,
    s_report
  } emu_state_t;

  // Next {B,A} code one step up: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] f_inc_val(input logic [1:0] ba);
    logic [1:0] nxt;
    unique case (ba)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Next {B,A} code one step down: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] f_dec_val(input logic [1:0] ba);
    logic [1:0] nxt;
    unique case (ba)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/encoder_step_timer.sv
// Step-period down-counter: loaded with P-1, emits a one-cycle tick at zero and reloads.
module encoder_step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] period_m1_i,
  input  logic             en_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] reload_q;
  logic [DIV_W-1:0] count_q;

  assign tick_o = en_i && !load_i && (count_q == '0);

  // Count down while enabled; a load restarts the period and captures the reload value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
      count_q  <= '0;
    end else if (load_i) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      reload_q <= period_m1_i;
      count_q  <= period_m1_i;
    end else if (en_i) begin
      count_q <= (count_q == '0) ? reload_q : count_q - 1'b1;
    end
  end

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature encoder emulator: walks A/B one count per step period toward a commanded
// target and reports the final position on a done stream.
module quadrature_encoder_emulator
  import encoder_pkg::*;
#(
  parameter int POS_W = 64,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_tvalid,
  output logic                    cmd_tready,
  input  logic signed [POS_W-1:0] cmd_tdata,
  input  logic        [DIV_W-1:0] step_period,
  input  logic                    abort,
  input  logic                    pos_load,
  input  logic signed [POS_W-1:0] pos_load_value,
  output logic                    encoder_a,
  output logic                    encoder_b,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done_tvalid,
  input  logic                    done_tready,
  output logic signed [POS_W-1:0] done_tdata
);

  emu_state_t              state_q, state_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic signed [POS_W-1:0] target_q, target_d;
  logic signed [POS_W-1:0] done_q, done_d;
  logic signed [POS_W-1:0] pos_base, pos_step;
  logic [1:0]              ab_q, ab_d;
  logic                    dir_up_q, dir_up_d;
  logic                    cmd_tready_q;
  logic                    cmd_accept;
  logic                    timer_load, timer_en, timer_tick;
  logic [DIV_W-1:0]        period_m1;

  // A period of 0 behaves as 1, so the reload value saturates at 0.
  assign period_m1  = (step_period == '0) ? '0 : step_period - 1'b1;
  assign cmd_accept = cmd_tvalid && cmd_tready_q;
  // A preset in IDLE takes effect before the target comparison of a same-cycle command.
  assign pos_base   = pos_load ? pos_load_value : pos_q;
  assign pos_step   = dir_up_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

  encoder_step_timer #(
    .DIV_W(DIV_W)
  ) u_step_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (timer_load),
    .period_m1_i(period_m1),
    .en_i       (timer_en),
    .tick_o     (timer_tick)
  );

  // Next-state logic: command accept, stepping, abort and done handshake.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    pos_d      = pos_q;
    target_d   = target_q;
    done_d     = done_q;
    ab_d       = ab_q;
    dir_up_d   = dir_up_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    unique case (state_q)
      s_idle: begin
        pos_d = pos_base;
        if (cmd_accept) begin
          target_d   = cmd_tdata;
          timer_load = 1'b1;
          if (cmd_tdata == pos_base) begin
            state_d = s_report;
            done_d  = pos_base;
          end else begin
            state_d  = s_run;
            dir_up_d = (cmd_tdata > pos_base);
          end
        end
      end
      s_run: begin
        timer_en = 1'b1;
        if (abort) begin
          // Abort wins over a due edge: no further count is emitted.
          state_d = s_report;
          done_d  = pos_q;
        end else if (timer_tick) begin
          pos_d = pos_step;
          ab_d  = dir_up_q ? f_inc_val(ab_q) : f_dec_val(ab_q);
          if (pos_step == target_q) begin
            state_d = s_report;
            done_d  = pos_step;
          end
        end
      end
      s_report: begin
        if (done_tready) state_d = s_idle;
      end
      default: state_d = s_idle;
    endcase
  end

  // State and datapath registers; reset forces A/B straight to 00.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= s_idle;
      pos_q        <= '0;
      target_q     <= '0;
      done_q       <= '0;
      ab_q         <= 2'b00;
      dir_up_q     <= 1'b0;
      cmd_tready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      target_q     <= target_d;
      done_q       <= done_d;
      ab_q         <= ab_d;
      dir_up_q     <= dir_up_d;
      cmd_tready_q <= (state_d == s_idle);
    end
  end

  assign cmd_tready  = cmd_tready_q;
  assign encoder_a   = ab_q[0];
  assign encoder_b   = ab_q[1];
  assign position    = pos_q;
  assign busy        = (state_q != s_idle);
  assign done_tvalid = (state_q == s_report);
  assign done_tdata  = done_q;

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Self-checking bench for quadrature_encoder_emulator: directed sequences, a vector table
// and randomized moves against a behavioural model with a Gray-code decoder as monitor.
module tb_quadrature_encoder_emulator;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cmd_tvalid = 1'b0;
  logic               cmd_tready;
  logic signed [63:0] cmd_tdata = '0;
  logic        [15:0] step_period = '0;
  logic               abort = 1'b0;
  logic               pos_load = 1'b0;
  logic signed [63:0] pos_load_value = '0;
  logic               encoder_a, encoder_b;
  logic signed [63:0] position;
  logic               busy, done_tvalid;
  logic               done_tready = 1'b0;
  logic signed [63:0] done_tdata;

  int checks = 0;
  int errors = 0;

  quadrature_encoder_emulator #(.POS_W(64), .DIV_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_tvalid    (cmd_tvalid),
    .cmd_tready    (cmd_tready),
    .cmd_tdata     (cmd_tdata),
    .step_period   (step_period),
    .abort         (abort),
    .pos_load      (pos_load),
    .pos_load_value(pos_load_value),
    .encoder_a     (encoder_a),
    .encoder_b     (encoder_b),
    .position      (position),
    .busy          (busy),
    .done_tvalid   (done_tvalid),
    .done_tready   (done_tready),
    .done_tdata    (done_tdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Independent quadrature decoder: Gray index difference mod 4 gives the step direction.
  longint mon_cnt = 0;
  int     mon_bad = 0;
  logic [1:0] mon_prev = 2'b00;

  function automatic int gidx(input logic [1:0] ba);
    case (ba)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_cnt  = 0;
      mon_prev = 2'b00;
    end else if ({encoder_b, encoder_a} != mon_prev) begin
      case ((gidx({encoder_b, encoder_a}) - gidx(mon_prev)) & 3)
        1:       mon_cnt = mon_cnt + 1;
        3:       mon_cnt = mon_cnt - 1;
        default: mon_bad = mon_bad + 1;
      endcase
      mon_prev = {encoder_b, encoder_a};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    cmd_tvalid = 1'b0; abort = 1'b0; pos_load = 1'b0; done_tready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) for cmd_tready, then present one command for one cycle.
  task automatic send_cmd(input logic signed [63:0] tgt, input int per,
                          input bit do_load, input logic signed [63:0] lv);
    int n = 0;
    while (!cmd_tready && n < 20) begin tick(); n++; end
    check("cmd_tready_before_cmd", cmd_tready, 1'b1);
    cmd_tvalid = 1'b1; cmd_tdata = tgt; step_period = 16'(per);
    pos_load = do_load; pos_load_value = lv;
    tick();
    cmd_tvalid = 1'b0; pos_load = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!done_tvalid && lat < budget) begin tick(); lat++; end
  endtask

  task automatic finish_handshake();
    done_tready = 1'b1;
    tick();
    done_tready = 1'b0;
    check("done_tvalid_after_handshake", done_tvalid, 1'b0);
  endtask

  typedef struct {
    logic signed [63:0] load_val;
    logic signed [63:0] target;
    int                 period;
    int                 exp_lat;
    logic signed [63:0] exp_final;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    longint mon0;

    vecs[0] = '{64'sd10, 64'sd7, 2, 6, 64'sd7};
    vecs[1] = '{-64'sd5, -64'sd5, 9, 0, -64'sd5};
    vecs[2] = '{64'sh7FFF_FFFF_FFFF_FFFE, 64'sh7FFF_FFFF_FFFF_FFFF, 3, 3, 64'sh7FFF_FFFF_FFFF_FFFF};
    vecs[3] = '{64'sh8000_0000_0000_0001, 64'sh8000_0000_0000_0000, 1, 1, 64'sh8000_0000_0000_0000};
    vecs[4] = '{-64'sd1, 64'sd1, 0, 2, 64'sd1};
    vecs[5] = '{64'sd2, -64'sd3, 3, 15, -64'sd3};

    // Reset values, and cmd_tready rising one edge after release.
    tick(); tick();
    check("rst_tready", cmd_tready, 1'b0);
    check("rst_ab", {encoder_b, encoder_a}, 2'b00);
    check("rst_position", position, 64'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_tvalid", done_tvalid, 1'b0);
    check("rst_done_tdata", done_tdata, 64'd0);
    reset_n = 1'b1;
    #1;
    check("tready_before_first_edge", cmd_tready, 1'b0);
    tick();
    check("tready_after_first_edge", cmd_tready, 1'b1);

    // Up move 0 -> 3 at period 4: edges at accept+4, +8, +12.
    send_cmd(64'sd3, 4, 1'b0, '0);
    check("run_tready_low", cmd_tready, 1'b0);
    check("run_busy", busy, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3)  check("up_no_edge_at_3", {encoder_b, encoder_a}, 2'b00);
      if (i == 4)  check("up_edge1_ab", {encoder_b, encoder_a}, 2'b01);
      if (i == 4)  check("up_edge1_pos", position, 64'd1);
      if (i == 8)  check("up_edge2_ab", {encoder_b, encoder_a}, 2'b11);
      if (i == 12) check("up_edge3_ab", {encoder_b, encoder_a}, 2'b10);
    end
    check("up_done_tvalid", done_tvalid, 1'b1);
    check("up_done_tdata", done_tdata, 64'sd3);
    finish_handshake();

    // Down move 0 -> -2 with period 0: edges on consecutive cycles.
    apply_reset();
    send_cmd(-64'sd2, 0, 1'b0, '0);
    tick();
    check("dn_edge1_ab", {encoder_b, encoder_a}, 2'b10);
    check("dn_edge1_pos", position, -64'sd1);
    tick();
    check("dn_edge2_ab", {encoder_b, encoder_a}, 2'b11);
    check("dn_done_tvalid", done_tvalid, 1'b1);
    check("dn_done_tdata", done_tdata, -64'sd2);
    finish_handshake();

    // Abort 35 cycles after accept at period 10: three edges only.
    apply_reset();
    send_cmd(64'sd100, 10, 1'b0, '0);
    for (int i = 1; i <= 34; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_position", position, 64'sd3);
    check("abort_done_tvalid", done_tvalid, 1'b1);
    check("abort_done_tdata", done_tdata, 64'sd3);
    check("abort_ab", {encoder_b, encoder_a}, 2'b10);
    tick(); tick();
    check("abort_no_more_edges", position, 64'sd3);
    finish_handshake();
    check("abort_busy_drops", busy, 1'b0);

    // Abort landing on a due edge suppresses that edge.
    apply_reset();
    send_cmd(64'sd100, 5, 1'b0, '0);
    for (int i = 1; i <= 9; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_on_edge_position", position, 64'sd1);
    check("abort_on_edge_done", done_tvalid, 1'b1);
    finish_handshake();

    // Back-pressure in REPORT: output stable; cmd, abort and pos_load ignored.
    apply_reset();
    send_cmd(64'sd2, 1, 1'b0, '0);
    wait_done(10, lat);
    check("bp_latency", lat, 2);
    for (int i = 0; i < 10; i++) begin
      cmd_tvalid = 1'b1; cmd_tdata = 64'sd50;
      pos_load = 1'b1; pos_load_value = 64'sd999; abort = 1'b1;
      tick();
      check("bp_done_tvalid", done_tvalid, 1'b1);
      check("bp_done_tdata", done_tdata, 64'sd2);
      check("bp_position", position, 64'sd2);
      check("bp_tready", cmd_tready, 1'b0);
    end
    cmd_tvalid = 1'b0; pos_load = 1'b0; abort = 1'b0;
    finish_handshake();
    check("bp_tready_back", cmd_tready, 1'b1);

    // Reset asserted mid-move returns everything to reset values at once.
    send_cmd(64'sd50, 2, 1'b0, '0);
    for (int i = 0; i < 7; i++) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_ab", {encoder_b, encoder_a}, 2'b00);
    check("midrst_position", position, 64'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tready", cmd_tready, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // Vector table: preset and command in the same cycle, then latency and final position.
    foreach (vecs[i]) begin
      mon0 = mon_cnt;
      send_cmd(vecs[i].target, vecs[i].period, 1'b1, vecs[i].load_val);
      wait_done(vecs[i].exp_lat + 5, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_done_tdata", i), done_tdata, vecs[i].exp_final);
      check($sformatf("vec%0d_position", i), position, vecs[i].exp_final);
      finish_handshake();
      check($sformatf("vec%0d_edge_count", i), 64'(mon_cnt - mon0),
            64'(vecs[i].exp_final - vecs[i].load_val));
    end

    // Randomized moves (some aborted) against the model, with the decoder as loopback.
    apply_reset();
    begin
      longint mpos = 0;
      for (int m = 0; m < 30; m++) begin
        longint tgt, n, edges, fin;
        int per, p, c, exp_lat;
        tgt = longint'($urandom_range(300)) - 150;
        per = int'($urandom_range(5));
        p   = (per == 0) ? 1 : per;
        n   = (tgt > mpos) ? tgt - mpos : mpos - tgt;
        c   = 0;
        if (n > 0 && $urandom_range(3) == 0) c = int'($urandom_range(1, int'(n) * p));
        edges   = (c > 0) ? longint'((c - 1) / p) : n;
        exp_lat = (c > 0) ? c : int'(n) * p;
        fin     = (tgt > mpos) ? mpos + edges : mpos - edges;
        send_cmd(tgt, per, 1'b0, '0);
        lat = 0;
        while (!done_tvalid && lat < exp_lat + 5) begin
          if (lat + 1 == c) abort = 1'b1;
          tick();
          abort = 1'b0;
          lat++;
        end
        check($sformatf("rnd%0d_latency", m), lat, exp_lat);
        check($sformatf("rnd%0d_done_tdata", m), done_tdata, fin);
        check($sformatf("rnd%0d_position", m), position, fin);
        finish_handshake();
        check($sformatf("rnd%0d_monitor_count", m), mon_cnt, position);
        mpos = fin;
      end
    end

    check("monitor_illegal_transitions", mon_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
